ex_pipe_stage: RTL
==================

EX_PIPE_STAGE -- requirements
Module: ex_pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of pc, immediate, operands and results.
REQ-002 Parameter AW, default 5: register-address width.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port in_valid  in  1 / in_ready  out  1: upstream handshake; transfer when both are high at a clk edge.
REQ-006 Port alu_op  in  4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 MUL (multicycle); 8-15 reserved.
REQ-007 Port aluSrc  in  1: 1 selects immediate as operand B, 0 selects rt_val.
REQ-008 Port reg_dst  in  1: 1 selects rd_addr, 0 selects rt_addr as destination.
REQ-009 Ports pc, immediate, rs_val, rt_val  in  WIDTH each: instruction operands.
REQ-010 Ports rt_addr, rd_addr  in  AW each: candidate destination addresses.
REQ-011 Port out_valid  out  1 / out_ready  in  1: downstream handshake; transfer when both are high at a clk edge.
REQ-012 Ports alu_out, pc_branch, rt_val_out  out  WIDTH; zero  out  1; reg_dst_addr  out  AW: registered results.
REQ-013 Port busy  out  1: high while a MUL is iterating.

Function
REQ-014 All outputs SHALL come from registers; no combinational path from inputs to result outputs.
REQ-015 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready).
REQ-016 On an accepted ALU op (0-6), the result SHALL be loaded and out_valid set at the same edge; out_valid is visible the next cycle; latency 1.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT SHALL yield 1 when rs_val < B as signed, else 0, zero-extended.
REQ-018 Reserved opcodes SHALL produce alu_out 0 and zero 1.
REQ-019 zero SHALL be 1 exactly when the registered alu_out equals 0.
REQ-020 pc_branch SHALL be pc + immediate + 1 modulo 2^WIDTH; rt_val_out SHALL be rt_val; reg_dst_addr SHALL be selected per reg_dst; all captured at acceptance.
REQ-021 FSM states SHALL be IDLE, MUL and DONE.
REQ-022 IDLE -> MUL on accepted MUL: latch rs_val, B and side fields; clear the accumulator and counter; busy=1.
REQ-023 MUL SHALL run shift-add, one multiplier bit per cycle, for exactly WIDTH cycles; result is the low WIDTH bits of the product.
REQ-024 After the last iteration: if !out_valid || out_ready, load the output and return to IDLE; otherwise go to DONE.
REQ-025 DONE SHALL hold the result and load it on the first cycle where !out_valid || out_ready, then return to IDLE.
REQ-026 While out_valid && !out_ready, all output registers SHALL hold their values.
REQ-027 A downstream pop and an upstream accept at the same edge SHALL sustain a throughput of one ALU op per cycle.
REQ-028 out_valid SHALL drop after a pop with no new result loaded at that edge.
REQ-029 Input changes while in_ready is low SHALL be ignored.

Reset
REQ-030 On reset, state SHALL be IDLE and out_valid, busy, alu_out, pc_branch, rt_val_out and reg_dst_addr SHALL be 0, with zero 1.
REQ-031 Reset asserted mid-MUL or in DONE SHALL abort the operation with no output produced; in_ready is 1 on the first cycle after reset deasserts.

Verification
REQ-032 Reset, then ADD rs=5, rt=7, aluSrc=0, reg_dst=1, rd=3, out_ready=1 -> next cycle out_valid=1, alu_out=12, zero=0, reg_dst_addr=3.
REQ-033 SUB rs=9, imm=9, aluSrc=1, pc=0x10 -> alu_out=0, zero=1, pc_branch=0x1A; SLT rs=0xFFFFFFFF, rt=1 -> alu_out=1.
REQ-034 MUL rs=6, rt=7 -> busy for 32 cycles, in_ready=0 throughout; out_valid at accept+33 with alu_out=42.
REQ-035 out_ready=0 with 3 ALU ops offered back-to-back -> only the first is accepted; output held stable; one accept per pop once out_ready rises.
REQ-036 MUL completes while out_ready=0 and out_valid=1 -> FSM in DONE, old output held; after the pop, alu_out=product.
REQ-037 Reset asserted 10 cycles into a MUL -> out_valid=0, busy=0, and an ADD issued next completes correctly.

Source files
------------

// File: rtl/ex_pipe_stage.sv
// ex_pipe_stage: execute stage with a one-cycle ALU path and an iterative
// shift-add multiplier. Results sit in a single output register slot guarded
// by a valid/ready handshake on both sides.
module ex_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             aluSrc,
  input  logic             reg_dst,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [AW-1:0]    rt_addr,
  input  logic [AW-1:0]    rd_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] pc_branch,
  output logic [WIDTH-1:0] rt_val_out,
  output logic             zero,
  output logic [AW-1:0]    reg_dst_addr,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] mcand_r, mplier_r, acc_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hold_pcb_r, hold_rt_r;
  logic [AW-1:0]    hold_dst_r;
  logic             out_valid_r, zero_r, busy_r;
  logic [WIDTH-1:0] alu_out_r, pc_branch_r, rt_val_out_r;
  logic [AW-1:0]    reg_dst_addr_r;

  logic             can_load_s, accept_s, is_mul_s, last_iter_s, mul_load_s;
  logic [WIDTH-1:0] opb_s, alu_res_s, pcb_s, mul_final_s, mul_value_s;
  logic [AW-1:0]    dst_s;

  // Single-cycle ALU; reserved and MUL opcodes yield zero on this path.
  function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~(a | b);
      4'd6:    r = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
      default: r = ZERO_W;
    endcase
    return r;
  endfunction

  assign can_load_s  = !out_valid_r || out_ready;
  assign in_ready    = (state_r == IDLE) && can_load_s;
  assign accept_s    = in_valid && in_ready;
  assign is_mul_s    = (alu_op == 4'd7);
  assign opb_s       = aluSrc ? immediate : rt_val;
  assign alu_res_s   = alu_calc(alu_op, rs_val, opb_s);
  assign pcb_s       = pc + immediate + ONE_W;
  assign dst_s       = reg_dst ? rd_addr : rt_addr;
  assign last_iter_s = (cnt_r == LAST_ITER);
  // Accumulator value including the current multiplier bit's partial product.
  assign mul_final_s = acc_r + (mplier_r[0] ? mcand_r : ZERO_W);
  assign mul_value_s = (state_r == DONE) ? acc_r : mul_final_s;
  assign mul_load_s  = can_load_s &&
                       (((state_r == MUL) && last_iter_s) || (state_r == DONE));

  assign out_valid    = out_valid_r;
  assign alu_out      = alu_out_r;
  assign pc_branch    = pc_branch_r;
  assign rt_val_out   = rt_val_out_r;
  assign zero         = zero_r;
  assign reg_dst_addr = reg_dst_addr_r;
  assign busy         = busy_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: MUL iterates, DONE parks a finished product until the
  // output slot frees up.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_mul_s) begin
          state_next_s = MUL;
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        if (last_iter_s) begin
          if (can_load_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = MUL;
        end
      end
      DONE: begin
        if (can_load_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Multiplier datapath: latch operands on accept, then one bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r    <= ZERO_W;
      mplier_r   <= ZERO_W;
      acc_r      <= ZERO_W;
      cnt_r      <= {CW{1'b0}};
      hold_pcb_r <= ZERO_W;
      hold_rt_r  <= ZERO_W;
      hold_dst_r <= {AW{1'b0}};
    end else if (accept_s && is_mul_s) begin
      mcand_r    <= rs_val;
      mplier_r   <= opb_s;
      acc_r      <= ZERO_W;
      cnt_r      <= {CW{1'b0}};
      hold_pcb_r <= pcb_s;
      hold_rt_r  <= rt_val;
      hold_dst_r <= dst_s;
    end else if (state_r == MUL) begin
      acc_r    <= mul_final_s;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

  // Busy flag mirrors the iterating state, registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == MUL);
    end
  end

  // Output slot: load ALU or MUL result, drop valid on a pop with no reload,
  // otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r    <= 1'b0;
      alu_out_r      <= ZERO_W;
      pc_branch_r    <= ZERO_W;
      rt_val_out_r   <= ZERO_W;
      reg_dst_addr_r <= {AW{1'b0}};
      zero_r         <= 1'b1;
    end else if (accept_s && !is_mul_s) begin
      out_valid_r    <= 1'b1;
      alu_out_r      <= alu_res_s;
      pc_branch_r    <= pcb_s;
      rt_val_out_r   <= rt_val;
      reg_dst_addr_r <= dst_s;
      zero_r         <= (alu_res_s == ZERO_W);
    end else if (mul_load_s) begin
      out_valid_r    <= 1'b1;
      alu_out_r      <= mul_value_s;
      pc_branch_r    <= hold_pcb_r;
      rt_val_out_r   <= hold_rt_r;
      reg_dst_addr_r <= hold_dst_r;
      zero_r         <= (mul_value_s == ZERO_W);
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule
